// File: rtl/ita_output_controller.sv
// Output controller: unpacks N-lane FIFO words into M-lane beats, MSB lane first,
// and tracks word/tile boundaries for last-beat and tile-done signalling.
module ita_output_controller #(
    parameter int N          = 16,
    parameter int WI         = 8,
    parameter int M          = 4,
    parameter int TILE_WORDS = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            fifo_empty_i,
    input  logic [N*WI-1:0] fifo_data_i,
    output logic            pop_from_fifo_o,
    output logic            oup_valid_o,
    input  logic            oup_ready_i,
    output logic [M*WI-1:0] oup_data_o,
    output logic            oup_last_o,
    output logic            tile_done_o,
    output logic            busy_o
);

    localparam int BEATS  = N / M;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = (TILE_WORDS > 1) ? $clog2(TILE_WORDS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(TILE_WORDS - 1);

    generate
        if (((N % M) != 0) || (TILE_WORDS < 1)) begin : g_param_check
            $error("ita_output_controller: N must be a multiple of M and TILE_WORDS >= 1");
        end
    endgenerate

    logic [N*WI-1:0]   word_q, word_d;
    logic              word_valid_q, word_valid_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              tile_done_q, tile_done_d;

    logic              handshake_s;
    logic              last_beat_s;
    logic              pop_s;
    logic [M*WI-1:0]   beat_data_s;

    assign handshake_s = word_valid_q & oup_ready_i;
    assign last_beat_s = handshake_s & (beat_q == BEAT_LAST);
    // rst_ni gate keeps the pop low while reset holds word_valid_q at zero
    assign pop_s       = rst_ni & ~clear_i & ~fifo_empty_i & (~word_valid_q | last_beat_s);

    // Beat selection as an AND-OR mux over register contents only
    always_comb begin
        beat_data_s = '0;
        for (int k = 0; k < BEATS; k++) begin
            beat_data_s = beat_data_s
                        | (word_q[(N - k*M)*WI-1 -: M*WI] & {(M*WI){beat_q == BEAT_W'(k)}});
        end
    end

    // Next-state: clear dominates, then pop, then end-of-word, then mid-word advance
    always_comb begin
        word_d       = word_q;
        word_valid_d = word_valid_q;
        beat_d       = beat_q;
        word_cnt_d   = word_cnt_q;
        tile_done_d  = 1'b0;
        if (clear_i) begin
            word_valid_d = 1'b0;
            beat_d       = '0;
            word_cnt_d   = '0;
            tile_done_d  = 1'b0;
        end else begin
            tile_done_d = handshake_s & oup_last_o;
            if (pop_s) begin
                word_d       = fifo_data_i;
                word_valid_d = 1'b1;
                beat_d       = '0;
            end else if (last_beat_s) begin
                word_valid_d = 1'b0;
                beat_d       = '0;
            end else if (handshake_s) begin
                beat_d = beat_q + BEAT_W'(1);
            end else begin
                beat_d = beat_q;
            end
            if (last_beat_s) begin
                word_cnt_d = (word_cnt_q == WORD_LAST) ? '0 : word_cnt_q + CNT_W'(1);
            end else begin
                word_cnt_d = word_cnt_q;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
            beat_q       <= '0;
            word_cnt_q   <= '0;
            tile_done_q  <= 1'b0;
        end else begin
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            beat_q       <= beat_d;
            word_cnt_q   <= word_cnt_d;
            tile_done_q  <= tile_done_d;
        end
    end

    assign pop_from_fifo_o = pop_s;
    assign oup_valid_o     = word_valid_q;
    assign oup_data_o      = beat_data_s;
    assign oup_last_o      = word_valid_q & (beat_q == BEAT_LAST) & (word_cnt_q == WORD_LAST);
    assign tile_done_o     = tile_done_q;
    assign busy_o          = word_valid_q;

endmodule

// File: tb/tb_ita_output_controller.sv
// Bench for ita_output_controller: table of words with expected beats feeding a
// FIFO model and a scoreboard, plus hand sequences for backpressure, clear and reset.
module tb_ita_output_controller;

    localparam int N  = 16;
    localparam int WI = 8;
    localparam int M  = 4;
    localparam int TW = 2;

    logic            clk;
    logic            rst_ni;
    logic            clear_i;
    logic            fifo_empty_i;
    logic [N*WI-1:0] fifo_data_i;
    logic            pop_from_fifo_o;
    logic            oup_valid_o;
    logic            oup_ready_i;
    logic [M*WI-1:0] oup_data_o;
    logic            oup_last_o;
    logic            tile_done_o;
    logic            busy_o;

    ita_output_controller #(.N(N), .WI(WI), .M(M), .TILE_WORDS(TW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_data_i    (fifo_data_i),
        .pop_from_fifo_o(pop_from_fifo_o),
        .oup_valid_o    (oup_valid_o),
        .oup_ready_i    (oup_ready_i),
        .oup_data_o     (oup_data_o),
        .oup_last_o     (oup_last_o),
        .tile_done_o    (tile_done_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] word;
        logic [31:0]  beats [4];
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          idx;
    } exp_t;

    vec_t         vecs [6];
    logic [127:0] fifo_q [$];
    exp_t         exp_q [$];

    int vectors = 0;
    int miscompares = 0;
    int tb_wcnt = 0;
    int pops = 0;
    int hs_cnt = 0;
    int bubbles = 0;
    bit bubble_watch = 1'b0;
    bit seen_hs = 1'b0;
    bit pop_pending = 1'b0;
    bit prev_hs_last = 1'b0;
    bit prev_clear = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push_word(input int v, input bit to_fifo, input bit to_exp);
        exp_t e;
        if (to_fifo) fifo_q.push_back(vecs[v].word);
        if (to_exp) begin
            for (int k = 0; k < 4; k++) begin
                e.data = vecs[v].beats[k];
                e.last = (k == 3) && (tb_wcnt == TW - 1);
                e.idx  = k;
                exp_q.push_back(e);
            end
            tb_wcnt = (tb_wcnt + 1) % TW;
        end
        refresh();
    endtask

    // One clock: inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        if (pop_pending && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        pop_pending = 1'b0;
        refresh();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || oup_valid_o) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(n >= budget), 64'(0));
        step();
        step();
    endtask

    task automatic wait_head(input int idx, input int budget);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < budget) begin
            step();
            n++;
            if (oup_valid_o && exp_q.size() > 0 && exp_q[0].idx == idx) found = 1'b1;
        end
        check("wait_head_timeout", 64'(found), 64'(1));
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({pop_from_fifo_o, oup_valid_o, oup_data_o, oup_last_o, tile_done_o, busy_o}), 64'(0));
    endtask

    // Scoreboard monitor, sampling on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (fifo_empty_i) check("pop_while_empty", 64'(pop_from_fifo_o), 64'(0));
                if (pop_from_fifo_o && oup_valid_o)
                    check("pop_beat", 64'({oup_ready_i, (exp_q.size() > 0) && (exp_q[0].idx == 3)}), 64'(2'b11));
                if (oup_valid_o && oup_ready_i) begin
                    hs_cnt++;
                    if (bubble_watch) seen_hs = 1'b1;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got %0h expected none at %0t", oup_data_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 64'(oup_data_o), 64'(e.data));
                        check("beat_last", 64'(oup_last_o), 64'(e.last));
                    end
                end else if (bubble_watch && seen_hs && exp_q.size() > 0 && !oup_valid_o) begin
                    bubbles++;
                end
                check("tile_done", 64'(tile_done_o), 64'(prev_hs_last && !prev_clear));
            end
            prev_hs_last = rst_ni && oup_valid_o && oup_ready_i && oup_last_o;
            prev_clear   = clear_i;
            pop_pending  = pop_from_fifo_o;
        end
    end

    initial begin
        int p0;
        int h0;
        vecs[0].word  = 128'h000102030405060708090A0B0C0D0E0F;
        vecs[0].beats = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        vecs[1].word  = 128'hFFEEDDCCBBAA99887766554433221100;
        vecs[1].beats = '{32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 32'h33221100};
        vecs[2].word  = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
        vecs[2].beats = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
        vecs[3].word  = 128'h808080807F7F7F7F00FF00FFA5A55A5A;
        vecs[3].beats = '{32'h80808080, 32'h7F7F7F7F, 32'h00FF00FF, 32'hA5A55A5A};
        vecs[4].word  = 128'h11111111222222223333333344444444;
        vecs[4].beats = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        vecs[5].word  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        vecs[5].beats = '{32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0};

        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        oup_ready_i = 1'b0;
        refresh();
        repeat (2) @(posedge clk);
        #1;

        // Reset with a word waiting: nothing may pop or appear
        push_word(0, 1'b1, 1'b1);
        #1;
        check_all_zero("reset_outputs");

        // Single word, four consecutive beats
        step();
        rst_ni       = 1'b1;
        oup_ready_i  = 1'b1;
        bubble_watch = 1'b1;
        seen_hs      = 1'b0;
        bubbles      = 0;
        p0           = pops;
        drain(100);
        check("single_pops", 64'(pops - p0), 64'(1));
        check("single_bubbles", 64'(bubbles), 64'(0));

        // Three words back to back; completes the second tile
        seen_hs = 1'b0;
        bubbles = 0;
        p0      = pops;
        h0      = hs_cnt;
        push_word(1, 1'b1, 1'b1);
        push_word(2, 1'b1, 1'b1);
        push_word(3, 1'b1, 1'b1);
        drain(100);
        check("b2b_pops", 64'(pops - p0), 64'(3));
        check("b2b_beats", 64'(hs_cnt - h0), 64'(12));
        check("b2b_bubbles", 64'(bubbles), 64'(0));
        bubble_watch = 1'b0;

        // Backpressure on beat 2 with a second word queued
        push_word(4, 1'b1, 1'b1);
        push_word(5, 1'b1, 1'b1);
        wait_head(2, 50);
        oup_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 64'(oup_valid_o), 64'(1));
            check("bp_data", 64'(oup_data_o), 64'(vecs[4].beats[2]));
            check("bp_pop", 64'(pop_from_fifo_o), 64'(0));
        end
        oup_ready_i = 1'b1;
        drain(100);

        // Clear on beat 1 with the FIFO non-empty
        push_word(0, 1'b1, 1'b1);
        push_word(1, 1'b1, 1'b0);
        wait_head(1, 50);
        clear_i = 1'b1;
        #1;
        check("clr_pop", 64'(pop_from_fifo_o), 64'(0));
        step();
        check("clr_valid", 64'(oup_valid_o), 64'(0));
        clear_i = 1'b0;
        exp_q.delete();
        tb_wcnt = 0;
        push_word(1, 1'b0, 1'b1);
        #1;
        check("clr_next_pop", 64'(pop_from_fifo_o), 64'(1));
        drain(100);

        // Reset mid-word on beat 2, held two cycles
        push_word(2, 1'b1, 1'b1);
        push_word(3, 1'b1, 1'b0);
        wait_head(2, 50);
        rst_ni = 1'b0;
        #1;
        check_all_zero("rst_async");
        for (int i = 0; i < 2; i++) begin
            step();
            check_all_zero("rst_hold");
        end
        exp_q.delete();
        tb_wcnt = 0;
        push_word(3, 1'b0, 1'b1);
        push_word(4, 1'b1, 1'b1);
        rst_ni = 1'b1;
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
